// File: rtl/dmem_block_mover.sv
// Block copy/fill engine acting as a second master on the data-memory port: 2 cycles per copied word, 1 per filled word.
// There is no backpressure; start is honoured only in IDLE and dropped otherwise.
module dmem_block_mover #(
    parameter int nbits = 32,
    parameter int AW    = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [AW-1:0]    src_i,
    input  logic [AW-1:0]    dst_i,
    input  logic [AW:0]      len_i,
    input  logic [nbits-1:0] fill_val_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [AW:0]      count_o,
    output logic             mem_we_o,
    output logic [nbits-1:0] mem_a_o,
    output logic [nbits-1:0] mem_wd_o,
    input  logic [nbits-1:0] mem_rd_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] LEN_ZERO = '0;
    localparam logic [AW:0] LEN_ONE  = (AW+1)'(1);

    state_t           state_q;
    logic [AW-1:0]    src_p_q;
    logic [AW-1:0]    dst_p_q;
    logic [AW:0]      rem_q;
    logic [AW:0]      count_q;
    logic [nbits-1:0] data_q;
    logic             mode_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            src_p_q <= '0;
            dst_p_q <= '0;
            rem_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_p_q <= src_i;
                        dst_p_q <= dst_i;
                        rem_q   <= len_i;
                        mode_q  <= mode_i;
                        count_q <= '0;
                        if (len_i == LEN_ZERO) begin
                            state_q <= S_DONE;
                        end else if (mode_i) begin
                            data_q  <= fill_val_i;
                            state_q <= S_WRITE;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    data_q  <= mem_rd_i;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    // Pointers are AW bits wide, so they wrap naturally at the top of memory.
                    dst_p_q <= dst_p_q + 1'b1;
                    if (!mode_q) begin
                        src_p_q <= src_p_q + 1'b1;
                    end
                    rem_q   <= rem_q - 1'b1;
                    count_q <= count_q + 1'b1;
                    if (rem_q == LEN_ONE) begin
                        state_q <= S_DONE;
                    end else if (mode_q) begin
                        state_q <= S_WRITE;
                    end else begin
                        state_q <= S_READ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // All port outputs decode from registers only; reset clears them asynchronously.
    assign busy_o   = (state_q != S_IDLE);
    assign done_o   = (state_q == S_DONE);
    assign mem_we_o = (state_q == S_WRITE);
    assign count_o  = count_q;

    always_comb begin
        mem_a_o  = '0;
        mem_wd_o = '0;
        case (state_q)
            S_READ: begin
                mem_a_o = {{(nbits-AW){1'b0}}, src_p_q};
            end
            S_WRITE: begin
                mem_a_o  = {{(nbits-AW){1'b0}}, dst_p_q};
                mem_wd_o = data_q;
            end
            default: begin
                mem_a_o  = '0;
                mem_wd_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_block_mover.sv
module tb_dmem_block_mover;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  src = '0;
    logic [7:0]  dst = '0;
    logic [8:0]  len = '0;
    logic [31:0] fill_val = '0;
    logic        busy, done, mem_we;
    logic [8:0]  count;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] ram [0:255];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_a = '0;
    logic [31:0] pl_d = '0;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_addr [0:15];
    int rd_n;

    always #5 clk = ~clk;

    dmem_block_mover #(.nbits(32), .AW(8)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .mode_i     (mode),
        .src_i      (src),
        .dst_i      (dst),
        .len_i      (len),
        .fill_val_i (fill_val),
        .busy_o     (busy),
        .done_o     (done),
        .count_o    (count),
        .mem_we_o   (mem_we),
        .mem_a_o    (mem_a),
        .mem_wd_o   (mem_wd),
        .mem_rd_i   (mem_rd)
    );

    // Behavioural data memory: combinational read, write on rising edge.
    always @(posedge clk) begin
        if (mem_we)
            ram[mem_a[7:0]] <= mem_wd;
        else if (pl_we)
            ram[pl_a] <= pl_d;
    end
    assign mem_rd = ram[mem_a[7:0]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    // Runs one transfer; lat counts negedges after the start edge until done is seen.
    task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                       input logic [8:0] l, input logic [31:0] f, input int poke,
                       output int lat, output int wes, output logic [8:0] cnt);
        @(negedge clk);
        chk("idle_before_start", {30'd0, busy, done}, 32'd0);
        start = 1'b1; mode = m; src = s; dst = d; len = l; fill_val = f;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0; wes = 0; rd_n = 0; cnt = '0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            if (poke > 0 && k == poke) begin
                start = 1'b1; mode = 1'b1; dst = 8'hC0; len = 9'd3; fill_val = 32'h12345678;
            end
            if (poke > 0 && k == poke + 1) start = 1'b0;
            if (mem_we) wes++;
            if (busy && !done && !mem_we && rd_n < 16) begin
                rd_addr[rd_n] = mem_a;
                rd_n++;
            end
            if (done) begin
                lat = k;
                cnt = count;
                chk("busy_in_done", {31'd0, busy}, 32'd1);
                break;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        logic        m;
        logic [7:0]  s;
        logic [7:0]  d;
        logic [8:0]  l;
        logic [31:0] f;
        int          poke;
        int          exp_lat;
        int          exp_cnt;
        int          exp_we;
    } vec_t;

    vec_t vecs [0:6];
    int lat, wes;
    logic [8:0] cnt;

    initial begin
        vecs[0] = '{1'b0, 8'h10, 8'h80, 9'd4, 32'h0,        0, 9, 4, 4};
        vecs[1] = '{1'b1, 8'h00, 8'h20, 9'd3, 32'hDEADBEEF, 0, 4, 3, 3};
        vecs[2] = '{1'b0, 8'h00, 8'h60, 9'd0, 32'h0,        0, 1, 0, 0};
        vecs[3] = '{1'b0, 8'hFE, 8'h40, 9'd4, 32'h0,        0, 9, 4, 4};
        vecs[4] = '{1'b1, 8'h00, 8'h30, 9'd1, 32'h55,       0, 2, 1, 1};
        vecs[5] = '{1'b0, 8'h80, 8'h31, 9'd1, 32'h0,        0, 3, 1, 1};
        vecs[6] = '{1'b0, 8'h10, 8'hA0, 9'd2, 32'h0,        2, 5, 2, 2};

        #1;
        chk("rst_busy",   {31'd0, busy},   32'd0);
        chk("rst_done",   {31'd0, done},   32'd0);
        chk("rst_we",     {31'd0, mem_we}, 32'd0);
        chk("rst_count",  {23'd0, count},  32'd0);
        chk("rst_mem_a",  mem_a,           32'd0);
        chk("rst_mem_wd", mem_wd,          32'd0);

        for (int i = 0; i < 256; i++) preload(8'(i), 32'h1000_0000 | i);
        for (int i = 0; i < 4; i++) preload(8'h10 + 8'(i), 32'hA0 + i);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run(vecs[i].m, vecs[i].s, vecs[i].d, vecs[i].l, vecs[i].f, vecs[i].poke, lat, wes, cnt);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_count", i), {23'd0, cnt}, vecs[i].exp_cnt);
            chk($sformatf("v%0d_we_cycles", i), wes, vecs[i].exp_we);
            if (i == 3) begin
                chk("wrap_nreads", rd_n, 4);
                chk("wrap_rd0", rd_addr[0], 32'hFE);
                chk("wrap_rd1", rd_addr[1], 32'hFF);
                chk("wrap_rd2", rd_addr[2], 32'h00);
                chk("wrap_rd3", rd_addr[3], 32'h01);
            end
        end

        for (int i = 0; i < 4; i++) begin
            chk($sformatf("copy_dst%0d", i), ram[8'h80 + i], 32'hA0 + i);
            chk($sformatf("copy_src%0d", i), ram[8'h10 + i], 32'hA0 + i);
        end
        for (int i = 0; i < 3; i++) chk($sformatf("fill%0d", i), ram[8'h20 + i], 32'hDEADBEEF);
        chk("fill_untouched", ram[8'h23], 32'h1000_0023);
        chk("zero_len_untouched", ram[8'h60], 32'h1000_0060);
        chk("wrap_dst0", ram[8'h40], 32'h1000_00FE);
        chk("wrap_dst1", ram[8'h41], 32'h1000_00FF);
        chk("wrap_dst2", ram[8'h42], 32'h1000_0000);
        chk("wrap_dst3", ram[8'h43], 32'h1000_0001);
        chk("fill1", ram[8'h30], 32'h55);
        chk("copy1", ram[8'h31], 32'hA0);
        chk("busy_copy0", ram[8'hA0], 32'hA0);
        chk("busy_copy1", ram[8'hA1], 32'hA1);
        chk("busy_ignored", ram[8'hC0], 32'h1000_00C0);

        // Reset during the WRITE of word 3 of an 8-word copy.
        for (int i = 0; i < 8; i++) preload(8'h90 + 8'(i), 32'h0);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; src = 8'h50; dst = 8'h90; len = 9'd8;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_in_write3", {mem_we, mem_a[30:0]}, {1'b1, 31'h92});
        rst_n = 1'b0;
        #1;
        chk("midrst_we",   {31'd0, mem_we}, 32'd0);
        chk("midrst_busy", {31'd0, busy},   32'd0);
        chk("midrst_done", {31'd0, done},   32'd0);
        chk("midrst_a",    mem_a,           32'd0);
        chk("midrst_wd",   mem_wd,          32'd0);
        chk("midrst_cnt",  {23'd0, count},  32'd0);
        wes = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) wes++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) wes++;
        end
        chk("midrst_no_done", wes, 0);
        chk("midrst_w1", ram[8'h90], 32'h1000_0050);
        chk("midrst_w2", ram[8'h91], 32'h1000_0051);
        chk("midrst_w3", ram[8'h92], 32'h0);

        run(1'b0, 8'h50, 8'h98, 9'd2, 32'h0, 0, lat, wes, cnt);
        chk("post_rst_latency", lat, 5);
        chk("post_rst_count", {23'd0, cnt}, 32'd2);
        chk("post_rst_w0", ram[8'h98], 32'h1000_0050);
        chk("post_rst_w1", ram[8'h99], 32'h1000_0051);

        // Maximum length: whole memory filled, pointer wraps back to the start.
        run(1'b1, 8'h00, 8'h00, 9'h100, 32'hCAFEF00D, 0, lat, wes, cnt);
        chk("max_latency", lat, 257);
        chk("max_count", {23'd0, cnt}, 32'd256);
        chk("max_we", wes, 256);
        chk("max_ram00", ram[8'h00], 32'hCAFEF00D);
        chk("max_ramFF", ram[8'hFF], 32'hCAFEF00D);
        @(negedge clk);
        chk("count_hold", {23'd0, count}, 32'd256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_block_mover.md
# dmem_block_mover

Initiator-side block-transfer engine for the single-cycle MIPS data memory. Given a source address, destination address and word count, it drives the memory's `we` / `A` / `WD` inputs and samples `RD` to copy a block of words, or fills a block with a constant. It sits beside the datapath as a second master on the data-memory port, for memory initialisation and block moves. It is active only while the core is held off the port; port arbitration is external.

## Interface

- `nbits`, 32, data word width; matches the data memory.
- `AW`, 8, word-address width; the memory decodes `A[7:0]` only.
- `clk`  in  1  rising-edge clock; same clock as the data memory.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `mode`  in  1  0 = copy, 1 = fill.
- `src`  in  AW  source word address; ignored in fill mode.
- `dst`  in  AW  destination word address.
- `len`  in  AW+1  word count, 0..256.
- `fill_val`  in  nbits  fill pattern for mode 1.
- `busy`  out  1  high from the cycle after an accepted start until DONE is left.
- `done`  out  1  one-cycle completion pulse.
- `count`  out  AW+1  number of words written in the current or last transfer.
- `mem_we`  out  1  to the memory's `we`.
- `mem_a`  out  nbits  to the memory's `A`; upper bits are 0.
- `mem_wd`  out  nbits  to the memory's `WD`.
- `mem_rd`  in  nbits  from the memory's `RD`; combinational read while `we` = 0.

## Operation

- **State register:** IDLE, READ, WRITE, DONE.
- **Internal registers:**
  - `src_p`, `dst_p` (AW bits each).
  - `rem` (AW+1 bits).
  - `data` (nbits).
  - `mode_r`.
- **IDLE:**
  - If `start` = 1, latch `src`, `dst`, `len`, `mode`, `fill_val` and clear `count`.
  - If `len` = 0, go to DONE; there is no memory access.
  - Else if mode = 1, load `data` = `fill_val` and go to WRITE.
  - Else go to READ.
- **READ (copy only):**
  - Drive `mem_we` = 0 and `mem_a` = `src_p`.
  - At the clock edge, `data` <= `mem_rd` and go to WRITE.
- **WRITE:**
  - Drive `mem_we` = 1, `mem_a` = `dst_p`, `mem_wd` = `data`. The memory writes at this edge.
  - At the edge: `dst_p`++, `src_p`++ (copy only), `rem`--, `count`++.
  - If `rem` = 1 (last word), go to DONE.
  - Else go to READ (copy) or stay in WRITE (fill).
- **DONE:** `done` = 1 for this cycle only, then go to IDLE.
- **Address wrap-around:** pointers are AW bits and wrap mod 256 (0xFF -> 0x00).
- **Copy order:** always ascending. With overlapping regions and `dst` > `src`, the result is the forward-copy result (source words may be overwritten before they are read); this is the defined behaviour.
- **`start` outside IDLE** (READ/WRITE/DONE) is ignored; there is no queuing.
- **`mem_we`** is decoded only from the state register (WRITE), never from inputs, so it is glitch-free.
- **IDLE/READ/DONE outputs:** `mem_we` = 0. In IDLE and DONE, `mem_a` = 0 and `mem_wd` = 0. In READ, `mem_wd` = 0.

## Timing

- **Reset values:** state = IDLE; `busy`, `done`, `count`, `mem_we`, `mem_a`, `mem_wd` all 0; internal registers 0.
- **Reset mid-transfer:** asserting `rst_n` low forces `mem_we` to 0 asynchronously.
  - A write whose edge has not occurred is aborted.
  - Memory contents already written are kept.
  - No `done` pulse is produced.
- **Copy latency:** 2 cycles per word (READ + WRITE). `done` is asserted 2·len+1 cycles after the start edge.
- **Fill latency:** 1 cycle per word. `done` is asserted len+1 cycles after the start edge.
- **`len` = 0:** `done` is asserted 1 cycle after the start edge; `count` stays 0.
- **`busy`** = (state != IDLE). `busy` and `done` are both high in the DONE cycle.
- **Back-to-back:** a new `start` is accepted in the IDLE cycle immediately following DONE.
- **`count`** holds its final value until the next accepted start.

## Test plan

- **Copy:** preload RAM[0x10..0x13] = 0xA0..0xA3; start, mode = 0, src = 0x10, dst = 0x80, len = 4.
  - RAM[0x80..0x83] = 0xA0..0xA3.
  - `done` asserted 9 cycles after start; `count` = 4.
  - Source words unchanged.
- **Fill:** mode = 1, dst = 0x20, len = 3, fill_val = 0xDEADBEEF.
  - RAM[0x20..0x22] = 0xDEADBEEF; RAM[0x23] untouched.
  - `mem_we` high for exactly 3 consecutive cycles; `done` asserted 4 cycles after start.
- **Zero length:** len = 0.
  - `mem_we` never asserted; `done` pulse 1 cycle after start; `count` = 0.
- **Wrap-around:** src = 0xFE, dst = 0x40, len = 4.
  - Reads issued at 0xFE, 0xFF, 0x00, 0x01 in order.
  - RAM[0x40..0x43] match those four words.
- **Reset mid-operation:** drop `rst_n` during the WRITE of word 3 of a len = 8 copy.
  - All outputs go to 0 immediately; `done` never pulses.
  - Words 1-2 are written and word 3 is not.
  - A fresh start after reset completes normally.
- **Start while busy:** pulse `start` with new args during a transfer.
  - The transfer completes with the original args; the second request is not executed.
